mipi_dphy_lane_tx: RTL
======================

# mipi_dphy_lane_tx

Single-lane MIPI D-PHY transmit sequencer. It sequences one lane from LP-11 stop state into a high-speed burst and back again. Between the start and end of the burst it streams parallel bytes behind a leading 0xB8 sync byte. It sits between the packet builder and the serializer/LP pad drivers, and is the transmit-side counterpart of the receiver's line-reset logic: it produces the LP→HS→LP transitions that the receiver masks.

## Interface
Parameters:
- T_LPX, 4: LP-01 duration in clk_i cycles (1..255; 0 treated as 1)
- T_HS_PREPARE, 3: LP-00 duration in cycles (same range rule)
- T_HS_ZERO, 10: HS-0 (0x00 bytes) duration in cycles (same range rule)
- T_HS_TRAIL, 6: HS trail duration in cycles (same range rule)
- T_HS_EXIT, 8: post-burst LP-11 busy duration in cycles (same range rule)

Ports:
- clk_i  input  1  byte clock; all logic on rising edge
- reset_i  input  1  synchronous, active-high reset
- start_i  input  1  burst request; sampled only in IDLE
- data_i  input  8  payload byte; LSB is transmitted first on the wire
- data_valid_i  input  1  payload byte valid
- ready_o  output  1  byte accepted this cycle when ready_o && data_valid_i
- lp_o  output  2  LP levels {Dp,Dn}
- hs_en_o  output  1  HS driver enable
- hs_data_o  output  8  byte to the serializer
- busy_o  output  1  high in every state except IDLE
- done_o  output  1  one-cycle pulse on return to IDLE

## Operation
- All outputs are registered.
- Reset values: lp_o=2'b11, hs_en_o=0, hs_data_o=0x00, ready_o=0, busy_o=0, done_o=0, state=IDLE, counters=0.
- States and their outputs:
  - IDLE: lp_o=11, hs_en_o=0.
  - LPX: lp_o=01.
  - PREPARE: lp_o=00, hs_en_o=0.
  - ZERO: lp_o=00, hs_en_o=1, hs_data_o=0x00.
  - SYNC: hs_data_o=0xB8, ready_o=1.
  - DATA: hs_data_o=accepted byte, ready_o=1.
  - TRAIL: hs_en_o=1, ready_o=0, hs_data_o={8{~last_bit}}.
  - EXIT: lp_o=11, hs_en_o=0, busy_o=1.
- State transitions:
  - IDLE→LPX on start_i. start_i is ignored in every other state.
  - LPX, PREPARE, ZERO, TRAIL and EXIT each last exactly their parameter count in cycles, using one shared 8-bit down-counter that is loaded on state entry.
  - ZERO→SYNC lasts exactly 1 cycle.
  - SYNC/DATA: while ready_o=1 and data_valid_i=1, data_i appears on hs_data_o next cycle (state DATA).
  - SYNC/DATA: when ready_o=1 and data_valid_i=0, the next state is TRAIL. A gap in data_valid_i ends the burst; there is no stalling.
  - EXIT→IDLE; done_o=1 for the first IDLE cycle.
- last_bit is bit 7 of the last byte placed on hs_data_o. For a zero-length burst this is the sync byte, so the trail is 0x00.
- hs_data_o holds its last value whenever hs_en_o=0.
- reset_i mid-burst: the next cycle shows the reset values, with no trail, EXIT or done_o. The burst is truncated, which is accepted.
- Simultaneous reset_i and start_i: reset wins.

## Timing
- start_i high at edge k (IDLE) → lp_o=01 in cycles k+1..k+T_LPX.
- lp_o=00 then holds for T_HS_PREPARE cycles.
- HS phase:
  - hs_en_o rises on the first ZERO cycle.
  - 0x00 is driven for T_HS_ZERO cycles.
  - The sync cycle follows.
- Latency from start_i to the sync byte is T_LPX+T_HS_PREPARE+T_HS_ZERO+1 cycles (18 with defaults).
- A byte accepted at cycle c is on hs_data_o at c+1.
- N accepted bytes occupy N cycles after sync. The trail starts in the cycle after the first ready_o && !data_valid_i.
- The cycle after the last TRAIL cycle has hs_en_o=0 and lp_o=11.
- busy_o falls, and done_o pulses, T_HS_EXIT cycles after that.

## Test plan
- Defaults, start_i pulse, data_valid_i high for bytes 0x11,0x22,0x83 then low:
  - lp_o sequence is 11→01×4→00×3.
  - hs_data_o sequence is 0x00×10, 0xB8, 0x11, 0x22, 0x83, then 0x00×6 (bit7 of 0x83=1).
  - After the trail, lp_o=11 for 8 cycles, then done_o pulses.
- Last byte 0x7F → trail bytes 0xFF×6.
- Zero-length burst (data_valid_i low during SYNC) → 0xB8 followed directly by 0x00×6 trail. ready_o is high only during the sync cycle.
- start_i held high continuously → back-to-back bursts separated by exactly one IDLE cycle with lp_o=11 and done_o=1. start_i pulses during a burst have no effect.
- reset_i asserted in the 3rd DATA cycle → next cycle shows all outputs at their reset values. No done_o pulse follows. A later start_i begins a clean burst.
- Parameters set to 0 → each phase lasts 1 cycle, so latency from start_i to the sync byte is 4 cycles.

Source files
------------

// File: rtl/mipi_dphy_lane_tx.sv
// Single-lane D-PHY transmit sequencer: LP-11 -> LP-01 -> LP-00 -> HS-0 -> sync -> payload
// -> trail -> LP-11 exit. Outputs are registered and decoded from the next state.
module mipi_dphy_lane_tx #(
   parameter int T_LPX        = 4,
   parameter int T_HS_PREPARE = 3,
   parameter int T_HS_ZERO    = 10,
   parameter int T_HS_TRAIL   = 6,
   parameter int T_HS_EXIT    = 8
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [7:0] data_i,
   input  logic       data_valid_i,
   output logic       ready_o,
   output logic [1:0] lp_o,
   output logic       hs_en_o,
   output logic [7:0] hs_data_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LPX, S_PREPARE, S_ZERO, S_SYNC, S_DATA, S_TRAIL, S_EXIT
   } state_t;

   // Counter is loaded with duration-1 so a phase ends when it reads zero; 0 behaves as 1.
   function automatic logic [7:0] load_val(input int t);
      if (t <= 1) return 8'd0;
      return 8'(t - 1);
   endfunction

   localparam logic [7:0] LD_LPX   = load_val(T_LPX);
   localparam logic [7:0] LD_PREP  = load_val(T_HS_PREPARE);
   localparam logic [7:0] LD_ZERO  = load_val(T_HS_ZERO);
   localparam logic [7:0] LD_TRAIL = load_val(T_HS_TRAIL);
   localparam logic [7:0] LD_EXIT  = load_val(T_HS_EXIT);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] lp_q, lp_d;
   logic       hs_en_q, hs_en_d;
   logic [7:0] hs_data_q, hs_data_d;
   logic       ready_q, ready_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         lp_q      <= 2'b11;
         hs_en_q   <= 1'b0;
         hs_data_q <= 8'h00;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lp_q      <= lp_d;
         hs_en_q   <= hs_en_d;
         hs_data_q <= hs_data_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start_i) state_d = S_LPX;
         S_LPX:     if (cnt_q == 8'd0) state_d = S_PREPARE;
         S_PREPARE: if (cnt_q == 8'd0) state_d = S_ZERO;
         S_ZERO:    if (cnt_q == 8'd0) state_d = S_SYNC;
         S_SYNC,
         S_DATA:    state_d = data_valid_i ? S_DATA : S_TRAIL;
         S_TRAIL:   if (cnt_q == 8'd0) state_d = S_EXIT;
         S_EXIT:    if (cnt_q == 8'd0) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         case (state_d)
            S_LPX:     cnt_d = LD_LPX;
            S_PREPARE: cnt_d = LD_PREP;
            S_ZERO:    cnt_d = LD_ZERO;
            S_TRAIL:   cnt_d = LD_TRAIL;
            S_EXIT:    cnt_d = LD_EXIT;
            default:   cnt_d = 8'd0;
         endcase
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_comb begin
      lp_d      = 2'b11;
      hs_en_d   = 1'b0;
      hs_data_d = hs_data_q;
      ready_d   = 1'b0;
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_IDLE) && (state_q == S_EXIT);
      case (state_d)
         S_LPX:     lp_d = 2'b01;
         S_PREPARE: lp_d = 2'b00;
         S_ZERO: begin
            lp_d      = 2'b00;
            hs_en_d   = 1'b1;
            hs_data_d = 8'h00;
         end
         S_SYNC: begin
            lp_d      = 2'b00;
            hs_en_d   = 1'b1;
            hs_data_d = 8'hB8;
            ready_d   = 1'b1;
         end
         S_DATA: begin
            lp_d      = 2'b00;
            hs_en_d   = 1'b1;
            hs_data_d = data_i;
            ready_d   = 1'b1;
         end
         S_TRAIL: begin
            lp_d    = 2'b00;
            hs_en_d = 1'b1;
            // Trail level is latched once on entry; re-evaluating would toggle it every cycle.
            if (state_q != S_TRAIL) hs_data_d = {8{~hs_data_q[7]}};
         end
         default: ;
      endcase
   end

   assign lp_o      = lp_q;
   assign hs_en_o   = hs_en_q;
   assign hs_data_o = hs_data_q;
   assign ready_o   = ready_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule
